// File: rtl/vector_alu_seq_if.sv
// Start/done coprocessor bus for the sequential vector ALU.
// The master issues operations and the slave returns element results, flags and the reduction.
interface vector_alu_seq_if #(
    parameter int WIDTH = 32,
    parameter int VLEN  = 8
);
    logic                  start;
    logic [2:0]            ALUOp;
    logic [VLEN*WIDTH-1:0] a;
    logic [VLEN*WIDTH-1:0] b;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [VLEN*WIDTH-1:0] Result;
    logic [WIDTH-1:0]      RedSum;
    logic [3:0]            ALUFlags;
    logic                  op_err;

    modport master (
        output start, ALUOp, a, b,
        input  ready, busy, done, Result, RedSum, ALUFlags, op_err
    );

    modport slave (
        input  start, ALUOp, a, b,
        output ready, busy, done, Result, RedSum, ALUFlags, op_err
    );
endinterface

// File: rtl/vector_alu_seq.sv
// Multi-cycle vector ALU: LANES elements per RUN beat, NZCV aggregate and wrap-around sum.
// state | meaning
// IDLE  | waiting for start, outputs hold the last result
// RUN   | one beat per cycle, LANES elements each
// DONE  | one-cycle done pulse, a new start is accepted here
module vector_alu_seq #(
    parameter int WIDTH = 32,
    parameter int VLEN  = 8,
    parameter int LANES = 2
) (
    input  logic            clk,
    input  logic            reset,
    vector_alu_seq_if.slave bus
);
    localparam int BEATS = VLEN / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VW    = VLEN * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [VW-1:0]    a_q, b_q, result_q, result_d;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] beat_q;
    logic [WIDTH-1:0] redsum_q, redsum_d, beat_sum;
    logic [3:0]       flags_q, flags_d;
    logic             op_err_q;
    logic             accept, last_beat;
    logic [WIDTH-1:0] lane_x   [LANES];
    logic [WIDTH-1:0] lane_y   [LANES];
    logic [WIDTH+3:0] lane_out [LANES];

    // Returns {N, Z, C, V, result} for one element.
    function automatic logic [WIDTH+3:0] alu_elem(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] p, q, r;
        logic             cin, arith, c, v;
        p     = x;
        q     = y;
        cin   = 1'b0;
        arith = 1'b1;
        r     = '0;
        c     = 1'b0;
        v     = 1'b0;
        case (op)
            3'b000:  ;
            3'b001:  begin q = ~y; cin = 1'b1; end
            3'b101:  begin p = y; q = ~x; cin = 1'b1; end
            default: arith = 1'b0;
        endcase
        s = {1'b0, p} + {1'b0, q} + {{WIDTH{1'b0}}, cin};
        if (arith) begin
            r = s[WIDTH-1:0];
            c = s[WIDTH];
            v = (p[WIDTH-1] == q[WIDTH-1]) && (r[WIDTH-1] != p[WIDTH-1]);
        end else begin
            case (op)
                3'b010:  r = x & y;
                3'b011:  r = x | y;
                3'b100:  r = x ^ y;
                default: r = '0;
            endcase
        end
        return {r[WIDTH-1], (r == '0), c, v, r};
    endfunction

    assign accept    = bus.start && (state_q != RUN);
    assign last_beat = (beat_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_beat) state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat selection uses constant slices so every lane is a plain mux over beats.
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_x[k] = '0;
            lane_y[k] = '0;
            for (int g = 0; g < BEATS; g++) begin
                if (beat_q == CNT_W'(g)) begin
                    lane_x[k] = a_q[(g*LANES+k)*WIDTH +: WIDTH];
                    lane_y[k] = b_q[(g*LANES+k)*WIDTH +: WIDTH];
                end
            end
            lane_out[k] = alu_elem(op_q, lane_x[k], lane_y[k]);
            beat_sum    = beat_sum + lane_out[k][WIDTH-1:0];
            flags_d     = {flags_d[3] | lane_out[k][WIDTH+3],
                           flags_d[2] & lane_out[k][WIDTH+2],
                           flags_d[1] | lane_out[k][WIDTH+1],
                           flags_d[0] | lane_out[k][WIDTH]};
            for (int g = 0; g < BEATS; g++) begin
                if (beat_q == CNT_W'(g))
                    result_d[(g*LANES+k)*WIDTH +: WIDTH] = lane_out[k][WIDTH-1:0];
            end
        end
        redsum_d = redsum_q + beat_sum;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            redsum_q <= '0;
            flags_q  <= 4'b0100;
            op_err_q <= 1'b0;
            beat_q   <= '0;
        end else if (accept) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            op_q     <= bus.ALUOp;
            result_q <= '0;
            redsum_q <= '0;
            flags_q  <= 4'b0100;
            op_err_q <= bus.ALUOp[2] & bus.ALUOp[1];
            beat_q   <= '0;
        end else if (state_q == RUN) begin
            result_q <= result_d;
            redsum_q <= redsum_d;
            flags_q  <= flags_d;
            beat_q   <= beat_q + CNT_W'(1);
        end
    end

    assign bus.ready    = (state_q != RUN);
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.Result   = result_q;
    assign bus.RedSum   = redsum_q;
    assign bus.ALUFlags = flags_q;
    assign bus.op_err   = op_err_q;
endmodule

// File: tb/tb_vector_alu_seq.sv
// Bench for vector_alu_seq: directed vector table, reset/back-to-back sequences and random ops vs a model.
module tb_vector_alu_seq;
    localparam int W  = 32;
    localparam int VL = 8;
    localparam int LN = 2;
    localparam int VW = VL * W;
    localparam int LAT = VL / LN + 1;

    typedef logic [VW-1:0] vec_t;
    typedef struct {
        string      name;
        logic [2:0] op;
        vec_t       a;
        vec_t       b;
        vec_t       res;
        logic [W-1:0] sum;
        logic [3:0] fl;
        logic       err;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    vector_alu_seq_if #(.WIDTH(W), .VLEN(VL)) bus();
    vector_alu_seq #(.WIDTH(W), .VLEN(VL), .LANES(LN)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic vec_t set_el(input vec_t v, input int i, input logic [W-1:0] x);
        vec_t t;
        t = v;
        t[i*W +: W] = x;
        return t;
    endfunction

    // Reference model from arithmetic definitions: carry = no borrow for subtraction, V from signed range.
    task automatic model(input logic [2:0] op, input vec_t a, input vec_t b,
                         output vec_t res, output logic [W-1:0] sum,
                         output logic [3:0] fl, output logic err);
        longint ua, ub, sa, sb, full, sfull;
        logic [W-1:0] r;
        logic c, v, n, z, cc, vv;
        res = '0; sum = '0; n = 0; z = 1; cc = 0; vv = 0;
        err = (op == 3'd6) || (op == 3'd7);
        for (int i = 0; i < VL; i++) begin
            ua = longint'({32'd0, a[i*W +: W]});
            ub = longint'({32'd0, b[i*W +: W]});
            sa = longint'($signed(a[i*W +: W]));
            sb = longint'($signed(b[i*W +: W]));
            c = 0; v = 0; r = '0; full = 0; sfull = 0;
            case (op)
                3'd0: begin full = ua + ub; sfull = sa + sb; c = (full >= 64'h1_0000_0000); end
                3'd1: begin full = ua - ub; sfull = sa - sb; c = (ua >= ub); end
                3'd5: begin full = ub - ua; sfull = sb - sa; c = (ub >= ua); end
                default: ;
            endcase
            case (op)
                3'd0, 3'd1, 3'd5: begin
                    r = full[W-1:0];
                    v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
                end
                3'd2: r = a[i*W +: W] & b[i*W +: W];
                3'd3: r = a[i*W +: W] | b[i*W +: W];
                3'd4: r = a[i*W +: W] ^ b[i*W +: W];
                default: r = '0;
            endcase
            res[i*W +: W] = r;
            sum = sum + r;
            n  = n | r[W-1];
            z  = z & (r == '0);
            cc = cc | c;
            vv = vv | v;
        end
        fl = {n, z, cc, vv};
    endtask

    // Issues one operation, scrambles the inputs after acceptance and waits for done.
    task automatic run_op(input logic [2:0] op, input vec_t a, input vec_t b,
                          output int lat, output int busy_cnt, output logic err_c1);
        @(negedge clk);
        bus.start = 1'b1; bus.ALUOp = op; bus.a = a; bus.b = b;
        lat = -1; busy_cnt = 0; err_c1 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.start = 1'b0; bus.ALUOp = ~op; bus.a = ~a; bus.b = a ^ b;
                err_c1 = bus.op_err;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin lat = n; break; end
        end
    endtask

    rec_t tbl[6];
    vec_t ea, eb, eres, exp_r;
    logic [W-1:0] esum;
    logic [3:0] efl;
    logic eerr, err_c1;
    int lat, bcnt, done_seen;

    initial begin
        bus.start = 0; bus.ALUOp = 0; bus.a = '0; bus.b = '0;

        // directed vectors
        for (int t = 0; t < 6; t++) begin
            tbl[t].a = '0; tbl[t].b = '0; tbl[t].res = '0; tbl[t].err = 0;
        end
        tbl[0].name = "add_ramp"; tbl[0].op = 3'b000; tbl[0].sum = 32'd108; tbl[0].fl = 4'b0000;
        for (int i = 0; i < VL; i++) begin
            tbl[0].a   = set_el(tbl[0].a, i, 32'(i));
            tbl[0].b   = set_el(tbl[0].b, i, 32'd10);
            tbl[0].res = set_el(tbl[0].res, i, 32'(10 + i));
        end
        tbl[1].name = "sub_wrap"; tbl[1].op = 3'b001; tbl[1].sum = 32'hFFFFFFFF; tbl[1].fl = 4'b1010;
        for (int i = 1; i < VL; i++) begin
            tbl[1].a = set_el(tbl[1].a, i, 32'd5);
            tbl[1].b = set_el(tbl[1].b, i, 32'd5);
        end
        tbl[1].b   = set_el(tbl[1].b, 0, 32'd1);
        tbl[1].res = set_el(tbl[1].res, 0, 32'hFFFFFFFF);
        tbl[2].name = "add_ovf"; tbl[2].op = 3'b000; tbl[2].sum = 32'h80000000; tbl[2].fl = 4'b1001;
        tbl[2].a   = set_el(tbl[2].a, 3, 32'h7FFFFFFF);
        tbl[2].b   = set_el(tbl[2].b, 3, 32'd1);
        tbl[2].res = set_el(tbl[2].res, 3, 32'h80000000);
        tbl[3].name = "add_carry"; tbl[3].op = 3'b000; tbl[3].sum = 32'd0; tbl[3].fl = 4'b0110;
        tbl[3].a   = set_el(tbl[3].a, 3, 32'hFFFFFFFF);
        tbl[3].b   = set_el(tbl[3].b, 3, 32'd1);
        tbl[4].name = "and_zero"; tbl[4].op = 3'b010; tbl[4].sum = 32'd0; tbl[4].fl = 4'b0100;
        for (int i = 0; i < VL; i++) begin
            tbl[4].a = set_el(tbl[4].a, i, 32'hAAAAAAAA);
            tbl[4].b = set_el(tbl[4].b, i, 32'h55555555);
        end
        tbl[5] = tbl[4];
        tbl[5].name = "reserved"; tbl[5].op = 3'b110; tbl[5].err = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", VW'(bus.ready), VW'(1));
        chk("rst_busy", VW'(bus.busy), VW'(0));
        chk("rst_done", VW'(bus.done), VW'(0));
        chk("rst_result", bus.Result, '0);
        chk("rst_redsum", VW'(bus.RedSum), VW'(0));
        chk("rst_flags", VW'(bus.ALUFlags), VW'(4'b0100));
        chk("rst_operr", VW'(bus.op_err), VW'(0));
        reset = 1'b1;

        for (int t = 0; t < 6; t++) begin
            run_op(tbl[t].op, tbl[t].a, tbl[t].b, lat, bcnt, err_c1);
            chk({tbl[t].name, "_lat"}, VW'(lat), VW'(LAT));
            chk({tbl[t].name, "_busy"}, VW'(bcnt), VW'(LAT - 1));
            chk({tbl[t].name, "_result"}, bus.Result, tbl[t].res);
            chk({tbl[t].name, "_redsum"}, VW'(bus.RedSum), VW'(tbl[t].sum));
            chk({tbl[t].name, "_flags"}, VW'(bus.ALUFlags), VW'(tbl[t].fl));
            chk({tbl[t].name, "_operr"}, VW'(bus.op_err), VW'(tbl[t].err));
            chk({tbl[t].name, "_operr_c1"}, VW'(err_c1), VW'(tbl[t].err));
        end

        // reset during RUN cycle 2
        @(negedge clk);
        bus.start = 1'b1; bus.ALUOp = 3'b000; bus.a = tbl[0].a; bus.b = tbl[0].b;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("midrst_busy_before", VW'(bus.busy), VW'(1));
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready", VW'(bus.ready), VW'(1));
        chk("midrst_busy", VW'(bus.busy), VW'(0));
        chk("midrst_result", bus.Result, '0);
        chk("midrst_flags", VW'(bus.ALUFlags), VW'(4'b0100));
        reset = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 8; n++) begin
            if (bus.done) done_seen++;
            @(negedge clk);
        end
        chk("midrst_no_done", VW'(done_seen), VW'(0));

        // back-to-back: second start held through RUN, accepted only at DONE
        ea = '0; eb = '0;
        for (int i = 0; i < VL; i++) begin
            ea = set_el(ea, i, $urandom); eb = set_el(eb, i, $urandom);
        end
        @(negedge clk);
        bus.start = 1'b1; bus.ALUOp = 3'b000; bus.a = tbl[0].a; bus.b = tbl[2].a;
        @(negedge clk);
        bus.ALUOp = 3'b100; bus.a = ea; bus.b = eb;
        lat = -1;
        for (int n = 2; n <= 20; n++) begin
            @(negedge clk);
            if (bus.done) begin lat = n; break; end
        end
        model(3'b000, tbl[0].a, tbl[2].a, eres, esum, efl, eerr);
        chk("b2b_lat1", VW'(lat), VW'(LAT));
        chk("b2b_ready_at_done", VW'(bus.ready), VW'(1));
        chk("b2b_result1", bus.Result, eres);
        chk("b2b_redsum1", VW'(bus.RedSum), VW'(esum));
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin bus.start = 1'b0; bus.a = ~ea; bus.b = '0; bus.ALUOp = 3'b000; end
            if (bus.done) begin lat = n; break; end
        end
        model(3'b100, ea, eb, eres, esum, efl, eerr);
        chk("b2b_lat2", VW'(lat), VW'(LAT));
        chk("b2b_result2", bus.Result, eres);
        chk("b2b_flags2", VW'(bus.ALUFlags), VW'(efl));

        // random ops against the model
        for (int t = 0; t < 40; t++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            ea = '0; eb = '0;
            for (int i = 0; i < VL; i++) begin
                case ($urandom_range(0, 3))
                    0: begin ea = set_el(ea, i, $urandom); eb = set_el(eb, i, $urandom); end
                    1: begin ea = set_el(ea, i, 32'($urandom_range(0, 3)));
                             eb = set_el(eb, i, 32'($urandom_range(0, 3))); end
                    2: begin ea = set_el(ea, i, ($urandom_range(0, 1) != 0) ? 32'h7FFFFFFF : 32'h80000000);
                             eb = set_el(eb, i, ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'd1); end
                    default: begin ea = set_el(ea, i, $urandom); eb = set_el(eb, i, ea[i*W +: W]); end
                endcase
            end
            run_op(op, ea, eb, lat, bcnt, err_c1);
            model(op, ea, eb, exp_r, esum, efl, eerr);
            chk($sformatf("rnd%0d_op%0d_lat", t, op), VW'(lat), VW'(LAT));
            chk($sformatf("rnd%0d_op%0d_result", t, op), bus.Result, exp_r);
            chk($sformatf("rnd%0d_op%0d_redsum", t, op), VW'(bus.RedSum), VW'(esum));
            chk($sformatf("rnd%0d_op%0d_flags", t, op), VW'(bus.ALUFlags), VW'(efl));
            chk($sformatf("rnd%0d_op%0d_operr", t, op), VW'(bus.op_err), VW'(eerr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vector_alu_seq.md
Name: vector_alu_seq

Overview:
Multi-cycle vector ALU. It applies one operation element-wise to two VLEN-element operand vectors, using LANES parallel ALU lanes per cycle. It accumulates ARM-style NZCV flags across all elements and produces a wrap-around sum of the result elements. It sits beside the datapath as a start/done coprocessor for vector instructions and generalises the fixed 5-lane combinational vector ALU in element count, lane count and reduction.

Parameters:
WIDTH, 32, element width in bits
VLEN, 8, elements per vector; must be a multiple of LANES
LANES, 2, elements processed per RUN cycle; must be at least 1

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
start  input  1  request a new operation; accepted only when ready=1
ALUOp  input  3  operation code, sampled with an accepted start
a  input  VLEN*WIDTH  operand vector; element i is a[i*WIDTH +: WIDTH]
b  input  VLEN*WIDTH  operand vector, same packing as a
ready  output  1  unit can accept start (state != RUN)
busy  output  1  state == RUN
done  output  1  one-cycle pulse; result outputs valid
Result  output  VLEN*WIDTH  element results, same packing as a
RedSum  output  WIDTH  sum of all Result elements, mod 2^WIDTH
ALUFlags  output  4  {N,Z,C,V} aggregate
op_err  output  1  the latched ALUOp was reserved

Behaviour:
- Reset (reset=0 at a clk edge) forces:
  - state=IDLE; ready=1, busy=0, done=0
  - Result=0, RedSum=0, ALUFlags=4'b0100, op_err=0
  - Reset wins over start and aborts any RUN in progress; no done is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 moves to RUN.
  - RUN: after VLEN/LANES beats, moves to DONE.
  - DONE: start=1 moves to RUN; otherwise moves to IDLE.
  - start is ignored while in RUN; it is neither queued nor an error.
- On an accepted start:
  - a, b and ALUOp are latched into internal registers; inputs may change afterwards.
  - Result, RedSum, beat counter and op_err are cleared.
  - The flag accumulator is set to N=0, Z=1, C=0, V=0.
- RUN beat g (g = 0 .. VLEN/LANES-1):
  - Lanes k = 0..LANES-1 compute element i = g*LANES+k.
  - Each element result is written to Result element i at the clk edge ending the beat.
  - RedSum += sum of that beat's element results, mod 2^WIDTH.
- ALUOp encoding (per element):
  - 000: add, a+b
  - 001: sub, a+~b+1
  - 010: and
  - 011: or
  - 100: xor
  - 101: sub-reverse, b+~a+1
  - 110, 111: reserved; result=0, op_err=1 from the first RUN cycle until the next start or reset.
- Per-element flags:
  - N = result MSB; Z = (result==0).
  - Add/sub ops: C = carry-out of the WIDTH-bit adder; V = signed overflow.
  - Logical and reserved ops: C=0, V=0.
- Aggregate flags:
  - N = OR of element N; Z = AND of element Z; C = OR of element C; V = OR of element V.
  - ALUFlags shows the running accumulator during RUN and is final when done=1.
- Timing:
  - Start accepted in cycle 0; RUN occupies cycles 1..VLEN/LANES; done=1 in cycle VLEN/LANES+1.
  - Start-to-done latency = VLEN/LANES+1 cycles.
  - Back-to-back: start asserted during DONE gives done and ready both 1 that cycle, then RUN in the next cycle.
- Outputs hold their values through DONE and IDLE until the next accepted start or reset.
- Lanes are combinational per beat; there is no internal pipelining.

Test Plan:
1. Reset mid-RUN: start ADD, drive reset=0 in RUN cycle 2 -> next cycle state IDLE, Result=0, ALUFlags=0100, no done pulse.
2. ADD, VLEN=8, LANES=2: a_i=i, b_i=10 -> done in cycle 5 exactly, Result_i=10+i, RedSum=108, ALUFlags=0000, busy high cycles 1-4.
3. SUB wrap: a_0=0, b_0=1, all other elements a_i=b_i=5 -> Result_0=FFFFFFFF, others 0, RedSum=FFFFFFFF, N=1, Z=0, C=1 (from the equal pairs), V=0.
4. ADD overflow: a_3=7FFFFFFF, b_3=1, rest 0 -> Result_3=80000000, N=1, V=1, C=0; repeat with a_3=FFFFFFFF -> C=1, Result_3=0.
5. AND of a=AAAAAAAA with b=55555555 for all elements -> all Result=0, Z=1, RedSum=0; then ALUOp=110 -> Result all 0, op_err=1, done still pulses in cycle 5.
6. Back-to-back: second start (XOR, new a/b) held during done cycle and during RUN -> accepted only at DONE, second done exactly 5 cycles later; the start pulses during RUN are ignored; operands changed after start do not affect the result.
